// File: rtl/distram14_pkg.sv
// distram14_pkg
// Shared constants and the capture FSM state type for the distram14 capture
// reader. One RAM32M16 gives 32 words x 16 bits; the upper pair (DIH) is
// unused, leaving 14 usable bits per lane.
package distram14_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int RAM_W = 14;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ARMED   = 2'd1,
    POST    = 2'd2,
    READOUT = 2'd3
  } state_t;

endpackage

// File: rtl/distram14_lane.sv
// distram14_lane
// One RAM32M16-equivalent lane: 32 x 14 distributed RAM with a synchronous
// write port and an asynchronous read port. The primitive's DIH pair is tied
// off, so only 14 data bits exist here.
//   clk_i   write clock
//   we      write enable
//   wraddr  write address
//   rdaddr  read address (combinational read)
//   din     write data
//   dout    read data, RAM[rdaddr]
module distram14_lane
  import distram14_pkg::*;
(
  input  logic             clk_i,
  input  logic             we,
  input  logic [AW-1:0]    wraddr,
  input  logic [AW-1:0]    rdaddr,
  input  logic [RAM_W-1:0] din,
  output logic [RAM_W-1:0] dout
);

  logic [RAM_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset, matching the LUT RAM primitive.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[wraddr] <= din;
    end
  end

  assign dout = mem[rdaddr];

endmodule

// File: rtl/distram14_capture_reader.sv
// distram14_capture_reader
// Trigger-frozen capture buffer. Samples are written continuously into a
// 32-deep circular buffer; a trigger (once the buffer has been filled) lets
// POSTTRIG more words in, then writes freeze and the 32-word window is
// streamed out oldest-first on a valid/ready master port.
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   dat_i      NSAMP lanes of NBITS, lane i at [NBITS*i +: NBITS]
//   trig_i     trigger, honoured only in ARMED
//   busy_o     high while in POST or READOUT
//   m_dat_o    readout data (registered), same lane mapping as dat_i
//   m_valid_o  readout valid
//   m_ready_i  downstream accept
//   m_last_o   marks the 32nd beat of the window
module distram14_capture_reader
  import distram14_pkg::*;
#(
  parameter int NSAMP    = 1,
  parameter int NBITS    = 14,
  parameter int POSTTRIG = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NBITS*NSAMP-1:0] dat_i,
  input  logic                   trig_i,
  output logic                   busy_o,
  output logic [NBITS*NSAMP-1:0] m_dat_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o
);

  localparam logic [AW-1:0] POST_END = AW'((POSTTRIG > 0) ? POSTTRIG - 1 : 0);

  state_t                 state;
  logic [AW-1:0]          wraddr;
  logic [AW-1:0]          wraddr_nxt;
  logic [AW-1:0]          rdaddr;
  logic [AW:0]            fill_cnt;
  logic [AW-1:0]          post_cnt;
  logic [AW-1:0]          beat_cnt;
  logic                   load_done;
  logic                   we;
  logic                   load;
  logic                   enter_readout;
  logic [NBITS*NSAMP-1:0] rd_word;

  assign we         = (state != READOUT);
  assign wraddr_nxt = wraddr + 1'b1;
  assign busy_o     = (state == POST) || (state == READOUT);

  // The output register may refill when it is empty or its beat is being
  // taken this cycle, as long as not all 32 beats have been loaded yet.
  assign load = (state == READOUT) && !load_done && (!m_valid_o || m_ready_i);

  // Writes freeze on the cycle the final post-trigger word is stored (or the
  // trigger word itself when POSTTRIG is 0).
  assign enter_readout = ((state == ARMED) && trig_i && (POSTTRIG == 0)) ||
                         ((state == POST) && (post_cnt == POST_END));

  // Lanes share both addresses; RAM bits above NBITS are written as zero.
  for (genvar i = 0; i < NSAMP; i++) begin : g_lane
    logic [RAM_W-1:0] din;
    logic [RAM_W-1:0] dout;
    logic             unused_dout;

    assign din = RAM_W'(dat_i[NBITS*i +: NBITS]);

    distram14_lane u_lane (
      .clk_i  (clk_i),
      .we     (we),
      .wraddr (wraddr),
      .rdaddr (rdaddr),
      .din    (din),
      .dout   (dout)
    );

    assign rd_word[NBITS*i +: NBITS] = dout[NBITS-1:0];
    assign unused_dout               = ^dout;
  end

  // Capture FSM, address pointers and the readout output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= FILL;
      wraddr    <= '0;
      rdaddr    <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      beat_cnt  <= '0;
      load_done <= 1'b0;
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_dat_o   <= '0;
    end else begin
      if (we) begin
        wraddr <= wraddr_nxt;
      end

      // At freeze the incremented write pointer names the oldest word.
      if (enter_readout) begin
        state     <= READOUT;
        rdaddr    <= wraddr_nxt;
        beat_cnt  <= '0;
        load_done <= 1'b0;
      end

      unique case (state)
        FILL: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == (AW+1)'(DEPTH - 1)) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (trig_i && (POSTTRIG != 0)) begin
            state    <= POST;
            post_cnt <= '0;
          end
        end
        POST: begin
          post_cnt <= post_cnt + 1'b1;
        end
        READOUT: begin
          if (load) begin
            m_dat_o   <= rd_word;
            m_valid_o <= 1'b1;
            m_last_o  <= (beat_cnt == AW'(DEPTH - 1));
            rdaddr    <= rdaddr + 1'b1;
            beat_cnt  <= beat_cnt + 1'b1;
            if (beat_cnt == AW'(DEPTH - 1)) begin
              load_done <= 1'b1;
            end
          end else if (m_valid_o && m_ready_i && m_last_o) begin
            // Window done: restart filling from scratch so the next window
            // never contains words from before this one.
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            state     <= FILL;
            fill_cnt  <= '0;
            wraddr    <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_distram14_capture_reader.sv
`timescale 1ns/1ps
// Bench for distram14_capture_reader. Four instances run from shared stimulus:
// POSTTRIG 8, 0 and 31 on a single 14-bit lane, plus a two-lane 12-bit copy
// with POSTTRIG 8. The reference model is a history array of every sample
// presented; a window triggered at sample t is hist[t-31+POSTTRIG .. t+POSTTRIG].
module tb_distram14_capture_reader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trig_i;
  logic        m_ready_i;
  logic [13:0] dat14;
  logic [23:0] dat24;

  logic        busy8, valid8, last8;
  logic [13:0] mdat8;
  logic        busy0, valid0, last0;
  logic [13:0] mdat0;
  logic        busy31, valid31, last31;
  logic [13:0] mdat31;
  logic        busyd, validd, lastd;
  logic [23:0] mdatd;

  int checks = 0;
  int errors = 0;

  int n;
  int hist [0:4095];
  bit ramp_mode;
  int tick_cnt = 0;
  int last_tick8;

  int          rx8[$];
  bit          rxl8[$];
  int          rx0[$];
  bit          rxl0[$];
  int          rx31[$];
  bit          rxl31[$];
  logic [23:0] rxd[$];
  bit          rxld[$];

  always #5 clk_i = ~clk_i;

  distram14_capture_reader #(.NSAMP(1), .NBITS(14), .POSTTRIG(8)) u_pt8 (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat14), .trig_i(trig_i), .busy_o(busy8),
    .m_dat_o(mdat8), .m_valid_o(valid8), .m_ready_i(m_ready_i), .m_last_o(last8));

  distram14_capture_reader #(.NSAMP(1), .NBITS(14), .POSTTRIG(0)) u_pt0 (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat14), .trig_i(trig_i), .busy_o(busy0),
    .m_dat_o(mdat0), .m_valid_o(valid0), .m_ready_i(m_ready_i), .m_last_o(last0));

  distram14_capture_reader #(.NSAMP(1), .NBITS(14), .POSTTRIG(31)) u_pt31 (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat14), .trig_i(trig_i), .busy_o(busy31),
    .m_dat_o(mdat31), .m_valid_o(valid31), .m_ready_i(m_ready_i), .m_last_o(last31));

  distram14_capture_reader #(.NSAMP(2), .NBITS(12), .POSTTRIG(8)) u_dual (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat24), .trig_i(trig_i), .busy_o(busyd),
    .m_dat_o(mdatd), .m_valid_o(validd), .m_ready_i(m_ready_i), .m_last_o(lastd));

  // Lane 1 of the dual instance carries the ramp inverted in 12 bits.
  function automatic logic [23:0] dual_word(int v);
    logic [11:0] lo;
    lo = 12'(v);
    return {lo ^ 12'hFFF, lo};
  endfunction

  task automatic present();
    hist[n] = ramp_mode ? n : int'($urandom_range(0, 16383));
    dat14   = 14'(hist[n]);
    dat24   = dual_word(hist[n]);
  endtask

  // One clock: record any beat transferred at this edge, then present the
  // next sample 1ns after the edge.
  task automatic tick();
    bit x8, x0, x31, xd;
    bit l8, l0, l31, ld;
    logic [13:0] d8, d0, d31;
    logic [23:0] dd;
    x8 = valid8 && m_ready_i;   d8 = mdat8;   l8 = last8;
    x0 = valid0 && m_ready_i;   d0 = mdat0;   l0 = last0;
    x31 = valid31 && m_ready_i; d31 = mdat31; l31 = last31;
    xd = validd && m_ready_i;   dd = mdatd;   ld = lastd;
    @(posedge clk_i);
    #1;
    tick_cnt++;
    if (x8) begin rx8.push_back(int'(d8)); rxl8.push_back(l8); last_tick8 = tick_cnt; end
    if (x0) begin rx0.push_back(int'(d0)); rxl0.push_back(l0); end
    if (x31) begin rx31.push_back(int'(d31)); rxl31.push_back(l31); end
    if (xd) begin rxd.push_back(dd); rxld.push_back(ld); end
    n++;
    present();
  endtask

  task automatic release_reset(bit ramp);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    ramp_mode = ramp;
    n         = 0;
    rx8.delete();  rxl8.delete();
    rx0.delete();  rxl0.delete();
    rx31.delete(); rxl31.delete();
    rxd.delete();  rxld.delete();
    present();
  endtask

  task automatic start_run(bit ramp);
    rst_i  = 1'b1;
    trig_i = 1'b0;
    @(posedge clk_i);
    #1;
    release_reset(ramp);
  endtask

  task automatic run_to(int v);
    while (n < v) tick();
  endtask

  task automatic pulse_trig();
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
  endtask

  task automatic wait_beats8(int want, int limit);
    int i = 0;
    while (rx8.size() < want && i < limit) begin
      tick();
      i++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; trig_i = 1'b0; m_ready_i = 1'b0; dat14 = '0; dat24 = '0;
    @(posedge clk_i);
    #1;
    checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy8); end
    checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", valid8); end
    checks++; if (last8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %0b expected 0", last8); end
    checks++; if (mdat8 !== 14'd0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", mdat8); end
    checks++; if (mdatd !== 24'd0) begin errors++; $display("[TB] FAIL reset_data_dual: got %0h expected 0", mdatd); end
  endtask

  task automatic test_ramp_all();
    int  i = 0;
    int  first8 = -1;
    bit  done8 = 0;
    int  t;
    start_run(1'b1);
    m_ready_i = 1'b1;
    run_to(100);
    checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL busy_before_trig: got %0b expected 0", busy8); end
    t = n;
    pulse_trig();
    checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_trig: got %0b expected 1", busy8); end
    checks++; if (busy31 !== 1'b1) begin errors++; $display("[TB] FAIL busy31_after_trig: got %0b expected 1", busy31); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("[TB] FAIL busy0_after_trig: got %0b expected 1", busy0); end
    checks++; if (busyd !== 1'b1) begin errors++; $display("[TB] FAIL busyd_after_trig: got %0b expected 1", busyd); end
    while ((rx8.size() < 32 || rx0.size() < 32 || rx31.size() < 32 || rxd.size() < 32) && i < 300) begin
      tick();
      i++;
      if (first8 < 0 && rx8.size() > 0) first8 = tick_cnt;
      if (rx8.size() < 32) begin
        checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL busy_in_window: got %0b expected 1 at n=%0d", busy8, n); end
      end else if (!done8) begin
        done8 = 1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL busy_release: got %0b expected 0", busy8); end
      end
    end
    checks++;
    if (rx8.size() < 32 || rx0.size() < 32 || rx31.size() < 32 || rxd.size() < 32) begin
      errors++;
      $display("[TB] FAIL ramp_timeout: beats %0d/%0d/%0d/%0d expected 32 each", rx8.size(), rx0.size(), rx31.size(), rxd.size());
    end
    checks++; if (last_tick8 - first8 !== 31) begin errors++; $display("[TB] FAIL full_throughput: span %0d expected 31", last_tick8 - first8); end
    for (int k = 0; k < 32; k++) begin
      if (k < rx8.size()) begin
        checks++; if (rx8[k] !== hist[t-23+k]) begin errors++; $display("[TB] FAIL pt8_beat%0d: got %0d expected %0d", k, rx8[k], hist[t-23+k]); end
        checks++; if (rxl8[k] !== (k == 31)) begin errors++; $display("[TB] FAIL pt8_last%0d: got %0b expected %0b", k, rxl8[k], k == 31); end
      end
      if (k < rx0.size()) begin
        checks++; if (rx0[k] !== hist[t-31+k]) begin errors++; $display("[TB] FAIL pt0_beat%0d: got %0d expected %0d", k, rx0[k], hist[t-31+k]); end
        checks++; if (rxl0[k] !== (k == 31)) begin errors++; $display("[TB] FAIL pt0_last%0d: got %0b expected %0b", k, rxl0[k], k == 31); end
      end
      if (k < rx31.size()) begin
        checks++; if (rx31[k] !== hist[t+k]) begin errors++; $display("[TB] FAIL pt31_beat%0d: got %0d expected %0d", k, rx31[k], hist[t+k]); end
        checks++; if (rxl31[k] !== (k == 31)) begin errors++; $display("[TB] FAIL pt31_last%0d: got %0b expected %0b", k, rxl31[k], k == 31); end
      end
      if (k < rxd.size()) begin
        checks++; if (rxd[k] !== dual_word(hist[t-23+k])) begin errors++; $display("[TB] FAIL dual_beat%0d: got %0h expected %0h", k, rxd[k], dual_word(hist[t-23+k])); end
        checks++; if (rxld[k] !== (k == 31)) begin errors++; $display("[TB] FAIL dual_last%0d: got %0b expected %0b", k, rxld[k], k == 31); end
      end
    end
    repeat (5) tick();
    checks++; if (rx8.size() !== 32) begin errors++; $display("[TB] FAIL pt8_extra_beats: got %0d expected 32", rx8.size()); end
  endtask

  task automatic test_backpressure();
    int   i = 0;
    int   t;
    bit   pv, pr, pl;
    logic [13:0] pd;
    start_run(1'b1);
    m_ready_i = 1'b1;
    run_to(100);
    t = n;
    pulse_trig();
    while (rx8.size() < 32 && i < 600) begin
      m_ready_i = 1'($urandom_range(0, 1));
      pv = valid8; pr = m_ready_i; pd = mdat8; pl = last8;
      tick();
      i++;
      if (pv && !pr) begin
        checks++;
        if (valid8 !== 1'b1 || mdat8 !== pd || last8 !== pl) begin
          errors++;
          $display("[TB] FAIL stall_hold: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b", valid8, mdat8, last8, pd, pl);
        end
      end
    end
    m_ready_i = 1'b1;
    checks++; if (rx8.size() !== 32) begin errors++; $display("[TB] FAIL bp_beat_count: got %0d expected 32", rx8.size()); end
    for (int k = 0; k < 32 && k < rx8.size(); k++) begin
      checks++; if (rx8[k] !== hist[t-23+k]) begin errors++; $display("[TB] FAIL bp_beat%0d: got %0d expected %0d", k, rx8[k], hist[t-23+k]); end
      checks++; if (rxl8[k] !== (k == 31)) begin errors++; $display("[TB] FAIL bp_last%0d: got %0b expected %0b", k, rxl8[k], k == 31); end
    end
  endtask

  task automatic test_early_late();
    int t1, t2, clear_idx;
    int i = 0;
    start_run(1'b0);
    m_ready_i = 1'b1;
    run_to(10);
    pulse_trig();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL trig_in_fill: got busy %0b expected 0", busy8); end
    run_to(50);
    t1 = n;
    pulse_trig();
    checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL trig_armed: got busy %0b expected 1", busy8); end
    run_to(53);
    pulse_trig();
    while (valid8 !== 1'b1 && i < 100) begin tick(); i++; end
    pulse_trig();
    wait_beats8(32, 200);
    clear_idx = n;
    checks++; if (rx8.size() !== 32) begin errors++; $display("[TB] FAIL el_beat_count: got %0d expected 32", rx8.size()); end
    for (int k = 0; k < 32 && k < rx8.size(); k++) begin
      checks++; if (rx8[k] !== hist[t1-23+k]) begin errors++; $display("[TB] FAIL el_beat%0d: got %0d expected %0d", k, rx8[k], hist[t1-23+k]); end
    end
    run_to(clear_idx + 31);
    pulse_trig();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL trig_refill_31: got busy %0b expected 0", busy8); end
    run_to(clear_idx + 40);
    checks++; if (rx8.size() !== 32) begin errors++; $display("[TB] FAIL no_spurious_window: got %0d beats expected 32", rx8.size()); end
    t2 = n;
    pulse_trig();
    checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL trig_refill_40: got busy %0b expected 1", busy8); end
    wait_beats8(64, 200);
    checks++; if (rx8.size() !== 64) begin errors++; $display("[TB] FAIL el2_beat_count: got %0d expected 64", rx8.size()); end
    for (int k = 0; k < 32 && 32 + k < rx8.size(); k++) begin
      checks++; if (rx8[32+k] !== hist[t2-23+k]) begin errors++; $display("[TB] FAIL el2_beat%0d: got %0d expected %0d", k, rx8[32+k], hist[t2-23+k]); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    start_run(1'b1);
    m_ready_i = 1'b1;
    run_to(100);
    pulse_trig();
    wait_beats8(10, 100);
    checks++; if (valid8 !== 1'b1) begin errors++; $display("[TB] FAIL mid_valid_before_rst: got %0b expected 1", valid8); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (valid8 !== 1'b0) begin errors++; $display("[TB] FAIL async_valid: got %0b expected 0", valid8); end
    checks++; if (last8 !== 1'b0) begin errors++; $display("[TB] FAIL async_last: got %0b expected 0", last8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %0b expected 0", busy8); end
    checks++; if (mdat8 !== 14'd0) begin errors++; $display("[TB] FAIL async_data: got %0h expected 0", mdat8); end
    release_reset(1'b1);
    run_to(20);
    pulse_trig();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("[TB] FAIL trig_after_rst_20: got busy %0b expected 0", busy8); end
    run_to(40);
    t = n;
    pulse_trig();
    checks++; if (busy8 !== 1'b1) begin errors++; $display("[TB] FAIL trig_after_rst_40: got busy %0b expected 1", busy8); end
    wait_beats8(32, 200);
    checks++; if (rx8.size() !== 32) begin errors++; $display("[TB] FAIL rm_beat_count: got %0d expected 32", rx8.size()); end
    for (int k = 0; k < 32 && k < rx8.size(); k++) begin
      checks++; if (rx8[k] !== hist[t-23+k]) begin errors++; $display("[TB] FAIL rm_beat%0d: got %0d expected %0d", k, rx8[k], hist[t-23+k]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_all();
    test_backpressure();
    test_early_late();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
